// File: rtl/pool_window_gen.sv
// pool_window_gen
// Streams raster-order pixels (all feature maps in parallel) and produces
// non-overlapping KER_SIZE x KER_SIZE pooling windows. Rows 0..KER_SIZE-2 of
// each band are parked in a line buffer; on the last band row the pixels are
// shifted through a short current-row register and each window is assembled
// when the last column of the window arrives.
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   in_valid    : in_act holds one pixel position (all fmaps)
//   in_ready    : block accepts a pixel this cycle
//   in_act      : fmap i at bits [(i+1)*NBITS-1 : i*NBITS]
//   out_valid   : out_act holds a complete window
//   out_ready   : consumer takes the window this cycle
//   out_act     : one window per fmap; element (r,c) at slot r*KER_SIZE+c
//   frame_done  : one-cycle pulse with the last window of a frame
//   state_dbg   : FSM state (0 = FILL, 1 = EMIT)
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid keeps its data stable until the transfer. The output
// register is a single slot, so input is stalled (in_ready=0) exactly while a
// window is held and not being taken; when it is taken, a new window may load
// in the same cycle.
module pool_window_gen #(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = 2,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NBITS*NFMAPS-1:0]             in_act,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NBITS*KER_SIZE*KER_SIZE-1:0]  out_act [NFMAPS-1:0],
  output logic                                frame_done,
  output logic                                state_dbg
);

  localparam int PW  = NBITS * NFMAPS;
  localparam int WW  = NBITS * KER_SIZE * KER_SIZE;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW  = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1;
  localparam int LBR = (KER_SIZE > 1) ? KER_SIZE - 1 : 1;

  typedef enum logic {S_FILL = 1'b0, S_EMIT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [BW-1:0]  band_q, band_d;    // row mod KER_SIZE
  logic [BW-1:0]  phase_q, phase_d;  // column mod KER_SIZE
  logic           out_valid_q, out_valid_d;
  logic           frame_done_q, frame_done_d;
  logic [WW-1:0]  out_act_q [NFMAPS];
  logic [WW-1:0]  out_act_d [NFMAPS];

  logic [PW-1:0]  lb_q  [LBR][IMG_W];
  logic [PW-1:0]  cur_q [LBR];
  logic [PW-1:0]  win_pix [KER_SIZE][KER_SIZE];

  logic accept, col_wrap, is_emit, win_done, last_pix;

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign col_wrap = (col_q == CW'(IMG_W - 1));
  // With a 1x1 kernel there are no buffered rows: every pixel is a window.
  assign is_emit  = (state_q == S_EMIT) || (KER_SIZE == 1);
  assign win_done = accept && is_emit && (phase_q == BW'(KER_SIZE - 1));
  assign last_pix = col_wrap && (row_q == RW'(IMG_H - 1));

  // Gather the KER_SIZE x KER_SIZE pixel grid of the window that completes
  // with the current input pixel. cur_q[0] is the most recent previous pixel.
  always_comb begin
    for (int r = 0; r < KER_SIZE; r++)
      for (int c = 0; c < KER_SIZE; c++)
        win_pix[r][c] = '0;
    for (int r = 0; r < KER_SIZE - 1; r++)
      for (int c = 0; c < KER_SIZE; c++)
        win_pix[r][c] = lb_q[r][col_q - CW'(KER_SIZE - 1 - c)];
    for (int c = 0; c < KER_SIZE - 1; c++)
      win_pix[KER_SIZE-1][c] = cur_q[KER_SIZE - 2 - c];
    win_pix[KER_SIZE-1][KER_SIZE-1] = in_act;
  end

  // Counters, FSM and output register next state.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    band_d       = band_q;
    phase_d      = phase_q;
    out_valid_d  = out_valid_q && !out_ready;
    frame_done_d = 1'b0;
    out_act_d    = out_act_q;

    if (accept) begin
      if (col_wrap) begin
        col_d   = '0;
        phase_d = '0;
        row_d   = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        band_d  = (band_q == BW'(KER_SIZE - 1)) ? '0 : band_q + 1'b1;
      end else begin
        col_d   = col_q + 1'b1;
        phase_d = (phase_q == BW'(KER_SIZE - 1)) ? '0 : phase_q + 1'b1;
      end

      unique case (state_q)
        S_FILL: if (KER_SIZE > 1 && col_wrap && band_q == BW'(KER_SIZE - 2))
                  state_d = S_EMIT;
        S_EMIT: if (col_wrap) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end

    if (win_done) begin
      out_valid_d  = 1'b1;
      frame_done_d = last_pix;
      for (int f = 0; f < NFMAPS; f++)
        for (int r = 0; r < KER_SIZE; r++)
          for (int c = 0; c < KER_SIZE; c++)
            out_act_d[f][(r*KER_SIZE+c)*NBITS +: NBITS] =
              win_pix[r][c][f*NBITS +: NBITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      band_q       <= '0;
      phase_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int f = 0; f < NFMAPS; f++) out_act_q[f] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      band_q       <= band_d;
      phase_q      <= phase_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_act_q    <= out_act_d;
    end
  end

  // Pixel storage carries no reset; stale contents are always overwritten
  // before they are read within a band.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!is_emit) begin
        for (int r = 0; r < KER_SIZE - 1; r++)
          if (band_q == BW'(r)) lb_q[r][col_q] <= in_act;
      end else begin
        cur_q[0] <= in_act;
        for (int j = 1; j < KER_SIZE - 1; j++) cur_q[j] <= cur_q[j-1];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_act    = out_act_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 SHALL have parameter NBITS, default 32, bit width of one activation.
REQ-002 SHALL have parameter NFMAPS, default 32, number of feature maps carried in parallel.
REQ-003 SHALL have parameter KER_SIZE, default 2, pooling window edge; stride equals KER_SIZE (non-overlapping).
REQ-004 SHALL have parameter IMG_W, default 8, feature-map width in pixels; multiple of KER_SIZE.
REQ-005 SHALL have parameter IMG_H, default 8, feature-map height in pixels; multiple of KER_SIZE.
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  in_act holds one pixel position for all fmaps.
REQ-009 SHALL have port in_ready  output  1  block accepts a pixel this cycle.
REQ-010 SHALL have port in_act  input  NBITS*NFMAPS  pixel; fmap i at bits [(i+1)*NBITS-1 : i*NBITS].
REQ-011 SHALL have port out_valid  output  1  out_act holds a complete window.
REQ-012 SHALL have port out_ready  input  1  consumer takes the window this cycle.
REQ-013 SHALL have port out_act  output  unpacked array [NFMAPS-1:0] of NBITS*KER_SIZE*KER_SIZE  window per fmap.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-015 Pixels SHALL arrive in raster order (column fastest); a pixel is accepted when in_valid && in_ready.
REQ-016 Window element at row r, column c (0 = top/left) SHALL occupy bits [(r*KER_SIZE+c+1)*NBITS-1 : (r*KER_SIZE+c)*NBITS] of each out_act entry.
REQ-017 Column counter SHALL count 0..IMG_W-1 and wrap to 0; row counter SHALL increment on column wrap and wrap to 0 after IMG_H-1.
REQ-018 State machine SHALL have states FILL (band rows 0..KER_SIZE-2) and EMIT (band row KER_SIZE-1).
REQ-019 FILL: accepted pixels SHALL be written into line buffer slot (row mod KER_SIZE, column); FILL->EMIT on column wrap of band row KER_SIZE-2.
REQ-020 EMIT: accepted pixel SHALL shift into a KER_SIZE-1 deep current-row register; when column mod KER_SIZE == KER_SIZE-1, the window SHALL be assembled from line buffer and current row plus the accepted pixel.
REQ-021 EMIT->FILL SHALL occur on column wrap; if KER_SIZE==1, FILL SHALL be skipped and every pixel is a window.
REQ-022 Assembled window SHALL be registered into out_act with out_valid=1 on the cycle after the completing pixel is accepted (latency 1).
REQ-023 out_valid and out_act SHALL hold stable until out_ready=1; out_valid clears after transfer unless a new window loads the same cycle.
REQ-024 in_ready SHALL equal !(out_valid && !out_ready); all input is stalled while a window is pending and not taken.
REQ-025 Window completion with out_valid=1 and out_ready=1 in the same cycle SHALL replace out_act with the new window, out_valid staying 1.
REQ-026 frame_done SHALL assert for exactly one cycle, the first cycle out_valid shows the window containing pixel (IMG_H-1, IMG_W-1).
REQ-027 A new frame SHALL be accepted immediately after the last pixel with no idle cycle required.
REQ-028 Data SHALL pass unmodified; no arithmetic on activations.

Reset
REQ-029 While rst=1: out_valid=0, frame_done=0, out_act all zeros, counters 0, state FILL, in_ready=1.
REQ-030 Reset mid-frame SHALL discard partial windows; the first pixel after reset release is pixel (0,0) of a new frame.
REQ-031 Line-buffer contents need not be reset.

Verification (NBITS=8, NFMAPS=1, KER_SIZE=2, IMG_W=4, IMG_H=4, pixel = row*4+col)
REQ-032 Stream 16 pixels, in_valid=1, out_ready=1 -> windows 0x05040100, 0x07060302, 0x0D0C0908, 0x0F0E0B0A, each one cycle after pixels 5, 7, 13, 15; frame_done with last only.
REQ-033 out_ready=0 from first window for 3 cycles -> out_act holds 0x05040100, in_ready=0 for those cycles, no pixel lost; remaining windows unchanged.
REQ-034 Two frames back-to-back (second = pixel+16) -> eight windows; second frame's first window 0x15141110; two frame_done pulses.
REQ-035 in_valid randomly deasserted 50% -> same window sequence as REQ-032.
REQ-036 rst pulsed after pixel 9 of frame, restart from pixel 0 -> out_valid=0 during reset, then exact REQ-032 sequence.
